// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file for the pipelined datapath.
//   - 2**ADDR_WIDTH registers of DATA_WIDTH bits, written on the rising edge.
//   - NUM_READ independent combinational read ports.
//   - Optional hard-wired zero register (register 0 reads 0, ignores writes,
//     never goes busy).
//   - Optional same-cycle write-to-read bypass.
//   - Per-register pending-write scoreboard. Decode uses it to spot RAW
//     hazards against in-flight writebacks.
//
// Parameters
//   DATA_WIDTH : bits per register
//   ADDR_WIDTH : register index width (depth = 2**ADDR_WIDTH)
//   NUM_READ   : number of read ports (1..8)
//   ZERO_REG   : 1 -> register 0 is hard-wired to zero
//   BYPASS     : 1 -> a same-cycle write is forwarded to matching read ports
//
// Ports
//   clock            in   rising-edge clock
//   ctrl_reset_n     in   asynchronous active-low reset (clears data and busy)
//   ctrl_writeEnable in   write strobe
//   ctrl_writeReg    in   write index
//   data_writeReg    in   write data
//   ctrl_busySet     in   mark ctrl_busyReg as pending a write
//   ctrl_busyReg     in   index to mark busy
//   ctrl_readReg     in   read indices, port i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   data_readReg     out  read data,    port i = [i*DATA_WIDTH +: DATA_WIDTH]
//   busy_readReg     out  port i's register has a pending write
//
// Interface contract: there is no handshake. Every strobe is accepted on
// every rising edge while ctrl_reset_n is high. Strobes seen at an edge
// while reset is low are ignored.
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                           clock,
   input  logic                           ctrl_reset_n,
   input  logic                           ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]          data_writeReg,
   input  logic                           ctrl_busySet,
   input  logic [ADDR_WIDTH-1:0]          ctrl_busyReg,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
   output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
   output logic [NUM_READ-1:0]            busy_readReg
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam bit ZERO_EN = (ZERO_REG != 0);
   localparam bit BYP_EN  = (BYPASS != 0);

   // Storage and scoreboard
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_busy;

   // Qualified strobes: a write or busy-set aimed at a hard-wired zero
   // register is dropped here, so nothing downstream needs to special-case it.
   logic                  w_wr_zero;
   logic                  w_wr_eff;
   logic                  w_set_zero;
   logic                  w_set_eff;
   logic [DEPTH-1:0]      w_busy_nxt;

   assign w_wr_zero  = ZERO_EN && (ctrl_writeReg == '0);
   assign w_wr_eff   = ctrl_writeEnable && !w_wr_zero;
   assign w_set_zero = ZERO_EN && (ctrl_busyReg == '0);
   assign w_set_eff  = ctrl_busySet && !w_set_zero;

   // ---------------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_eff) begin
         r_mem[ctrl_writeReg] <= data_writeReg;
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // The clear is applied before the set. When both hit the same index, the
   // set wins, because a newer producer has issued behind the completing one.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_eff) begin
         w_busy_nxt[ctrl_writeReg] = 1'b0;
      end
      if (w_set_eff) begin
         w_busy_nxt[ctrl_busyReg] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // The bypass compares against the qualified write. A discarded write to a
   // hard-wired register 0 therefore never forwards. Bypass is purely
   // combinational, so it also forwards while reset is held.
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_raddr;
      logic                  w_rzero;
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] w_rdata;
      logic                  w_rbusy;

      assign w_raddr = ctrl_readReg[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_rzero = ZERO_EN && (w_raddr == '0);
      assign w_hit   = BYP_EN && w_wr_eff && (ctrl_writeReg == w_raddr);

      always_comb begin
         w_rdata = r_mem[w_raddr];
         w_rbusy = r_busy[w_raddr];
         if (w_rzero) begin
            w_rdata = '0;
            w_rbusy = 1'b0;
         end else if (w_hit) begin
            // The value is being forwarded, so the hazard is already resolved.
            w_rdata = data_writeReg;
            w_rbusy = 1'b0;
         end
      end

      assign data_readReg[g*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
      assign busy_readReg[g]                          = w_rbusy;
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic clock;
   logic rst_n;

   // DUT A: defaults (32-bit, 32 regs, 2 ports, zero reg, bypass)
   logic        a_we, a_bs;
   logic [4:0]  a_wr, a_br;
   logic [31:0] a_wd;
   logic [9:0]  a_rr;
   logic [63:0] a_rd;
   logic [1:0]  a_rb;

   // DUT B: no bypass
   logic        b_we, b_bs;
   logic [4:0]  b_wr, b_br;
   logic [31:0] b_wd;
   logic [9:0]  b_rr;
   logic [63:0] b_rd;
   logic [1:0]  b_rb;

   // DUT C: 16-bit, 8 regs, 4 ports
   logic        c_we, c_bs;
   logic [2:0]  c_wr, c_br;
   logic [15:0] c_wd;
   logic [11:0] c_rr;
   logic [63:0] c_rd;
   logic [3:0]  c_rb;

   int n_checks = 0;
   int n_errors = 0;

   regfile_mp u_a (
      .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(a_we),
      .ctrl_writeReg(a_wr), .data_writeReg(a_wd), .ctrl_busySet(a_bs),
      .ctrl_busyReg(a_br), .ctrl_readReg(a_rr), .data_readReg(a_rd),
      .busy_readReg(a_rb));

   regfile_mp #(.BYPASS(0)) u_b (
      .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(b_we),
      .ctrl_writeReg(b_wr), .data_writeReg(b_wd), .ctrl_busySet(b_bs),
      .ctrl_busyReg(b_br), .ctrl_readReg(b_rr), .data_readReg(b_rd),
      .busy_readReg(b_rb));

   regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4)) u_c (
      .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEnable(c_we),
      .ctrl_writeReg(c_wr), .data_writeReg(c_wd), .ctrl_busySet(c_bs),
      .ctrl_busyReg(c_br), .ctrl_readReg(c_rr), .data_readReg(c_rd),
      .busy_readReg(c_rb));

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      a_we = 0; a_bs = 0; a_wr = 0; a_br = 0; a_wd = 0; a_rr = 0;
      b_we = 0; b_bs = 0; b_wr = 0; b_br = 0; b_wd = 0; b_rr = 0;
      c_we = 0; c_bs = 0; c_wr = 0; c_br = 0; c_wd = 0; c_rr = 0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // ---------------- vector table for DUT A ----------------
   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        bs;
      logic [4:0]  br;
      logic [4:0]  rr0;
      logic [4:0]  rr1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        b0;
      logic        b1;
   } vec_t;

   vec_t vecs[12];

   // ---------------- reference model for DUT A ----------------
   logic [31:0] m_mem [32];
   logic        m_busy [32];

   function automatic logic [31:0] model_data(input logic [4:0] addr);
      if (addr == 0) return 32'h0;
      if (a_we && a_wr == addr) return a_wd;
      return m_mem[addr];
   endfunction

   function automatic logic model_busy(input logic [4:0] addr);
      if (addr == 0) return 1'b0;
      if (a_we && a_wr == addr) return 1'b0;
      return m_busy[addr];
   endfunction

   task automatic model_edge();
      if (a_we && a_wr != 0) begin
         m_mem[a_wr]  = a_wd;
         m_busy[a_wr] = 1'b0;
      end
      if (a_bs && a_br != 0) m_busy[a_br] = 1'b1;
   endtask

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [15:0] c_val(input int i);
      return 16'(16'hA000 + i * 16'h0111);
   endfunction

   initial begin
      //                 we   wr     wd            bs   br     rr0    rr1    d0            d1            b0    b1
      vecs[0]  = '{1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 5'd3, 5'd9, 32'h0000_1234, 32'h0,         1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd3, 32'h0,         32'h0000_1234, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd3, 32'h0,         32'h0000_1234, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 5'd9, 32'h0000_00AA, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0000_00AA, 32'h0000_00AA, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd3, 32'h0000_00AA, 32'h0000_1234, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd9, 32'h0,         32'h0000_00AA, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 5'd4, 5'd0, 32'h0000_0044, 32'h0,         1'b0, 1'b0};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd4, 5'd4, 32'h0000_0044, 32'h0000_0044, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 5'd4, 32'h0000_0045, 1'b1, 5'd6, 5'd6, 5'd5, 32'h0,         32'h0,         1'b0, 1'b0};
      vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd4, 5'd6, 32'h0000_0045, 32'h0,         1'b0, 1'b1};

      // ---------------- reset ----------------
      idle_all();
      rst_n = 1'b0;
      #1;
      check("reset_a_d0", a_rd[31:0], 32'h0);
      check("reset_a_b", {30'h0, a_rb}, 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;

      // ---------------- table-driven vectors on DUT A ----------------
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         a_we = vecs[i].we; a_wr = vecs[i].wr; a_wd = vecs[i].wd;
         a_bs = vecs[i].bs; a_br = vecs[i].br;
         a_rr = {vecs[i].rr1, vecs[i].rr0};
         @(negedge clock);
         check($sformatf("vec%0d_d0", i), a_rd[31:0],  vecs[i].d0);
         check($sformatf("vec%0d_d1", i), a_rd[63:32], vecs[i].d1);
         check($sformatf("vec%0d_b0", i), {31'h0, a_rb[0]}, {31'h0, vecs[i].b0});
         check($sformatf("vec%0d_b1", i), {31'h0, a_rb[1]}, {31'h0, vecs[i].b1});
      end
      next_cycle();
      idle_all();

      // ---------------- reset mid-operation ----------------
      a_we = 1; a_wr = 5; a_wd = 32'hDEAD_BEEF;
      next_cycle();
      a_we = 0; a_bs = 1; a_br = 7;
      next_cycle();
      a_bs = 0; a_rr = {5'd7, 5'd5};
      @(negedge clock);
      check("pre_rst_r5", a_rd[31:0], 32'hDEAD_BEEF);
      check("pre_rst_busy7", {31'h0, a_rb[1]}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_r5", a_rd[31:0], 32'h0);
      check("rst_busy7", {31'h0, a_rb[1]}, 32'h0);
      a_we = 1; a_wr = 5; a_wd = 32'h99;
      #1;
      check("rst_bypass_r5", a_rd[31:0], 32'h99);
      check("rst_bypass_busy", {31'h0, a_rb[0]}, 32'h0);
      @(posedge clock);
      @(negedge clock);
      a_we = 0;
      rst_n = 1'b1;
      #1;
      check("rst_write_ignored", a_rd[31:0], 32'h0);
      next_cycle();
      a_we = 1; a_wr = 5; a_wd = 32'h1;
      next_cycle();
      a_we = 0;
      @(negedge clock);
      check("post_rst_r5", a_rd[31:0], 32'h1);

      // ---------------- no-bypass latency on DUT B ----------------
      next_cycle();
      b_we = 1; b_wr = 3; b_wd = 32'h1234; b_rr = {5'd3, 5'd3};
      @(negedge clock);
      check("nb_same_d0", b_rd[31:0], 32'h0);
      check("nb_same_d1", b_rd[63:32], 32'h0);
      next_cycle();
      b_we = 0;
      @(negedge clock);
      check("nb_next_d0", b_rd[31:0], 32'h1234);
      check("nb_next_d1", b_rd[63:32], 32'h1234);
      next_cycle();
      b_bs = 1; b_br = 2;
      next_cycle();
      b_bs = 0; b_we = 1; b_wr = 2; b_wd = 32'h55; b_rr = {5'd3, 5'd2};
      @(negedge clock);
      check("nb_wr_busy", {31'h0, b_rb[0]}, 32'h1);
      check("nb_wr_data", b_rd[31:0], 32'h0);
      next_cycle();
      b_we = 0;
      @(negedge clock);
      check("nb_after_busy", {31'h0, b_rb[0]}, 32'h0);
      check("nb_after_data", b_rd[31:0], 32'h55);

      // ---------------- parametrised DUT C ----------------
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         c_we = 1; c_wr = 3'(i); c_wd = (i == 0) ? 16'hFFFF : c_val(i);
      end
      next_cycle();
      c_we = 0;
      c_rr = {3'd2, 3'd4, 3'd1, 3'd7};
      @(negedge clock);
      check("c_p0_r7", {16'h0, c_rd[15:0]},  {16'h0, c_val(7)});
      check("c_p1_r1", {16'h0, c_rd[31:16]}, {16'h0, c_val(1)});
      check("c_p2_r4", {16'h0, c_rd[47:32]}, {16'h0, c_val(4)});
      check("c_p3_r2", {16'h0, c_rd[63:48]}, {16'h0, c_val(2)});
      check("c_busy", {28'h0, c_rb}, 32'h0);
      next_cycle();
      c_rr = {3'd7, 3'd3, 3'd6, 3'd0};
      @(negedge clock);
      check("c_p0_r0", {16'h0, c_rd[15:0]},  32'h0);
      check("c_p1_r6", {16'h0, c_rd[31:16]}, {16'h0, c_val(6)});
      check("c_p2_r3", {16'h0, c_rd[47:32]}, {16'h0, c_val(3)});
      check("c_p3_r7", {16'h0, c_rd[63:48]}, {16'h0, c_val(7)});

      // ---------------- randomized run on DUT A vs model ----------------
      next_cycle();
      idle_all();
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = 32'h0;
         m_busy[i] = 1'b0;
      end
      @(negedge clock);
      rst_n = 1'b1;
      for (int n = 0; n < 400; n++) begin
         next_cycle();
         a_we = 1'($urandom_range(0, 1));
         a_wr = rand_addr();
         a_wd = $urandom;
         a_bs = 1'($urandom_range(0, 1));
         a_br = rand_addr();
         a_rr = {rand_addr(), rand_addr()};
         @(negedge clock);
         check($sformatf("rnd%0d_d0", n), a_rd[31:0],  model_data(a_rr[4:0]));
         check($sformatf("rnd%0d_d1", n), a_rd[63:32], model_data(a_rr[9:5]));
         check($sformatf("rnd%0d_b0", n), {31'h0, a_rb[0]}, {31'h0, model_busy(a_rr[4:0])});
         check($sformatf("rnd%0d_b1", n), {31'h0, a_rb[1]}, {31'h0, model_busy(a_rr[9:5])});
         model_edge();
      end
      next_cycle();
      idle_all();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
